rx_data_link_layer: RTL and testbench

Receive-side PCIe-style data link layer stage. It accepts framed 32-bit words from the physical layer and checks each packet's sequence number and LCRC. Good TLPs are stored in a FIFO and released in order to the receive transaction layer on a 32-bit valid/ready stream; bad or out-of-sequence packets are discarded. Every packet outcome is reported as a one-cycle ACK/NAK pulse toward the transmit-side DLLP generator.

---
 rtl/rx_dll_pkg.sv | 18 +
 rtl/rx_dll_crc32_step.sv | 30 +++
 rtl/rx_data_link_layer.sv | 203 ++++++++++++++++++++
 tb/tb_rx_data_link_layer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_dll_pkg.sv
// rx_dll_pkg
//   Shared definitions for the receive data link layer: sequence number
//   width, CRC-32 constants and the receive FSM state encoding.
package rx_dll_pkg;

    localparam int SEQ_W = 12;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_dll_crc32_step.sv
// rx_dll_crc32_step
//   Combinational CRC-32 update over one 32-bit word, MSB first,
//   non-reflected, polynomial CRC32_POLY.
// Ports:
//   crc_in   - running CRC before this word
//   data_in  - word to fold into the CRC
//   crc_out  - running CRC after this word
module rx_dll_crc32_step
    import rx_dll_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out
);

    // Thirty-two serial LFSR steps unrolled into one cycle, bit 31 first.
    always_comb begin
        logic [31:0] v_crc;
        v_crc = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (v_crc[31] ^ data_in[i]) begin
                v_crc = {v_crc[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                v_crc = {v_crc[30:0], 1'b0};
            end
        end
        crc_out = v_crc;
    end

endmodule

// File: rtl/rx_data_link_layer.sv
// rx_data_link_layer
//   Receive-side data link layer. Checks sequence number, length and
//   (optionally) LCRC of each framed packet, buffers good TLP words in a
//   FIFO with speculative write / commit / read pointers, and reports every
//   packet outcome as a one-cycle ACK/NAK pulse.
// Configuration:
//   RX_DLL_LCRC_CHECK_EN - when defined, the eop word is checked against a
//   CRC-32 of the sop word and TLP words; when undefined the eop word is
//   discarded unchecked and no CRC logic is built.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   phy_data_in*                  - framed word stream from the PHY (valid/ready, sop/eop)
//   tlp_data_out*                 - committed TLP word stream (valid/ready)
//   ack_valid, ack_nak, ack_seq   - ACK/NAK report toward the DLLP generator
module rx_data_link_layer
    import rx_dll_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      phy_data_in,
    input  logic             phy_data_in_valid,
    input  logic             phy_data_in_sop,
    input  logic             phy_data_in_eop,
    output logic             phy_data_in_ready,
    output logic [31:0]      tlp_data_out,
    output logic             tlp_data_out_valid,
    input  logic             tlp_data_out_ready,
    output logic             ack_valid,
    output logic             ack_nak,
    output logic [SEQ_W-1:0] ack_seq
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_commit_ptr;
    logic [AW:0]      r_rd_ptr;
    rx_state_t        r_state;
    logic             r_hold_valid;
    logic [31:0]      r_hold_data;
    logic             r_has_tlp;
    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] r_next_seq;
    logic             r_ack_valid;
    logic             r_ack_nak;
    logic [SEQ_W-1:0] r_ack_seq;

    logic             w_full;
    logic             w_in_hs;
    logic             w_out_valid;
    logic             w_rd_hs;
    logic             w_mem_we;
    logic             w_lcrc_ok;
    logic             w_pkt_good;
    logic [AW:0]      w_wr_ptr_after;
    logic [SEQ_W-1:0] w_nak_seq;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full            = (r_wr_ptr - r_rd_ptr) == DEPTH_CNT;
    assign phy_data_in_ready = (r_state == DROP) || !(w_full && r_hold_valid);
    assign w_in_hs           = phy_data_in_valid && phy_data_in_ready;

    assign w_out_valid        = r_rd_ptr != r_commit_ptr;
    assign w_rd_hs            = w_out_valid && tlp_data_out_ready;
    assign tlp_data_out_valid = w_out_valid;
    assign tlp_data_out       = w_out_valid ? r_mem[r_rd_ptr[AW-1:0]] : 32'h0;

    // The held word goes into the FIFO when any further word of the packet
    // arrives, including the eop word; the eop word itself is never stored.
    assign w_mem_we       = w_in_hs && (r_state == RECV) && !phy_data_in_sop && r_hold_valid;
    assign w_wr_ptr_after = r_wr_ptr + (AW+1)'(w_mem_we);
    assign w_nak_seq      = r_next_seq - SEQ_W'(1);

    assign ack_valid = r_ack_valid;
    assign ack_nak   = r_ack_nak;
    assign ack_seq   = r_ack_seq;

`ifdef RX_DLL_LCRC_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_in;
    logic [31:0] w_crc_next;

    // A sop word always restarts the CRC, so stray words seen in IDLE or
    // DROP never leak into the next packet's LCRC.
    assign w_crc_in = phy_data_in_sop ? CRC32_INIT : r_crc;

    rx_dll_crc32_step u_crc_step (
        .crc_in  (w_crc_in),
        .data_in (phy_data_in),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= CRC32_INIT;
        end else if (w_in_hs && !phy_data_in_eop) begin
            r_crc <= w_crc_next;
        end
    end

    assign w_lcrc_ok = (r_crc ^ CRC32_XOROUT) == phy_data_in;
`else
    assign w_lcrc_ok = 1'b1;
`endif

    // A packet needs sop + at least one TLP word + eop to be non-runt.
    assign w_pkt_good = r_has_tlp && (r_seq == r_next_seq) && w_lcrc_ok;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_hold_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_state      <= IDLE;
            r_hold_valid <= 1'b0;
            r_hold_data  <= 32'h0;
            r_has_tlp    <= 1'b0;
            r_seq        <= '0;
            r_next_seq   <= '0;
            r_ack_valid  <= 1'b0;
            r_ack_nak    <= 1'b0;
            r_ack_seq    <= '1;
        end else begin
            r_ack_valid <= 1'b0;

            if (w_rd_hs) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end

            if (w_in_hs && phy_data_in_sop) begin
                // A sop in any state starts a new packet; a packet already in
                // progress is rolled back and NAKed. sop+eop is a runt.
                r_wr_ptr     <= r_commit_ptr;
                r_hold_valid <= 1'b0;
                r_has_tlp    <= 1'b0;
                r_seq        <= phy_data_in[SEQ_W-1:0];
                if ((r_state != IDLE) || phy_data_in_eop) begin
                    r_ack_valid <= 1'b1;
                    r_ack_nak   <= 1'b1;
                    r_ack_seq   <= w_nak_seq;
                end
                r_state <= phy_data_in_eop ? IDLE : RECV;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    RECV: begin
                        if (w_in_hs) begin
                            if (phy_data_in_eop) begin
                                r_hold_valid <= 1'b0;
                                r_ack_valid  <= 1'b1;
                                r_state      <= IDLE;
                                if (w_pkt_good) begin
                                    r_wr_ptr     <= w_wr_ptr_after;
                                    r_commit_ptr <= w_wr_ptr_after;
                                    r_ack_nak    <= 1'b0;
                                    r_ack_seq    <= r_seq;
                                    r_next_seq   <= r_next_seq + SEQ_W'(1);
                                end else begin
                                    r_wr_ptr  <= r_commit_ptr;
                                    r_ack_nak <= 1'b1;
                                    r_ack_seq <= w_nak_seq;
                                end
                            end else begin
                                r_wr_ptr     <= w_wr_ptr_after;
                                r_hold_data  <= phy_data_in;
                                r_hold_valid <= 1'b1;
                                r_has_tlp    <= 1'b1;
                            end
                        end else if (w_full && r_hold_valid && (r_commit_ptr == r_rd_ptr)) begin
                            // The whole buffer belongs to this packet and it
                            // still has more to store: it can never fit, so
                            // stop stalling the PHY and drain it.
                            r_hold_valid <= 1'b0;
                            r_state      <= DROP;
                        end
                    end
                    DROP: begin
                        if (w_in_hs && phy_data_in_eop) begin
                            r_wr_ptr    <= r_commit_ptr;
                            r_ack_valid <= 1'b1;
                            r_ack_nak   <= 1'b1;
                            r_ack_seq   <= w_nak_seq;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_data_link_layer.sv
// tb_rx_data_link_layer
//   Directed bench for rx_data_link_layer built with FIFO_DEPTH=8.
//   Expectations for the corrupted-LCRC packet follow RX_DLL_LCRC_CHECK_EN.
module tb_rx_data_link_layer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] phy_data_in = 32'h0;
    logic        phy_data_in_valid = 1'b0;
    logic        phy_data_in_sop = 1'b0;
    logic        phy_data_in_eop = 1'b0;
    logic        phy_data_in_ready;
    logic [31:0] tlp_data_out;
    logic        tlp_data_out_valid;
    logic        tlp_data_out_ready = 1'b1;
    logic        ack_valid;
    logic        ack_nak;
    logic [11:0] ack_seq;

    int assertCount = 0;
    int failCount = 0;

    logic [31:0] outQ[$];
    logic [12:0] ackQ[$];
    logic [31:0] txWords[$];
    bit          readyDropped = 1'b0;

    localparam logic [47:0] RESET_VIEW = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 12'hFFF};

    rx_data_link_layer #(.FIFO_DEPTH(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .phy_data_in        (phy_data_in),
        .phy_data_in_valid  (phy_data_in_valid),
        .phy_data_in_sop    (phy_data_in_sop),
        .phy_data_in_eop    (phy_data_in_eop),
        .phy_data_in_ready  (phy_data_in_ready),
        .tlp_data_out       (tlp_data_out),
        .tlp_data_out_valid (tlp_data_out_valid),
        .tlp_data_out_ready (tlp_data_out_ready),
        .ack_valid          (ack_valid),
        .ack_nak            (ack_nak),
        .ack_seq            (ack_seq)
    );

    always #5 clk = ~clk;

    // Outputs are stable mid-cycle; record transfers and ack pulses there.
    always @(negedge clk) begin
        if (tlp_data_out_valid && tlp_data_out_ready) outQ.push_back(tlp_data_out);
        if (ack_valid) ackQ.push_back({ack_nak, ack_seq});
    end

    // Reference CRC-32 (poly 04C11DB7, MSB first) over one word.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic e);
        int waitCyc;
        waitCyc = 0;
        @(negedge clk);
        phy_data_in = d; phy_data_in_sop = s; phy_data_in_eop = e; phy_data_in_valid = 1'b1;
        #1;
        while (!phy_data_in_ready && waitCyc < 100) begin
            readyDropped = 1'b1;
            @(negedge clk);
            #1;
            waitCyc++;
        end
        assertCount++;
        if (phy_data_in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL send_timeout: ready got %b, expected 1", phy_data_in_ready);
        end
        @(posedge clk);
        #1;
        phy_data_in_valid = 1'b0; phy_data_in_sop = 1'b0; phy_data_in_eop = 1'b0; phy_data_in = 32'h0;
    endtask

    task automatic send_packet(input logic [11:0] seq, input logic [31:0] flip);
        logic [31:0] sopWord;
        logic [31:0] c;
        sopWord = {20'h5A5A5, seq};
        c = crc_word(32'hFFFFFFFF, sopWord);
        send_word(sopWord, 1'b1, 1'b0);
        foreach (txWords[i]) begin
            c = crc_word(c, txWords[i]);
            send_word(txWords[i], 1'b0, 1'b0);
        end
        send_word(c ^ 32'hFFFFFFFF ^ flip, 1'b0, 1'b1);
    endtask

    task automatic pop_ack(output logic [13:0] a);
        if (ackQ.size() > 0) a = {1'b1, ackQ.pop_front()};
        else a = 14'h0;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        reset_n = 1'b0;
        tlp_data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {phy_data_in_ready, tlp_data_out_valid, tlp_data_out, ack_valid, ack_nak, ack_seq};
        assertCount++;
        if (got !== RESET_VIEW) begin
            failCount++;
            $display("[TB] FAIL reset_values: got %h, expected %h", got, RESET_VIEW);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(2);
        got = {phy_data_in_ready, tlp_data_out_valid, tlp_data_out, ack_valid, ack_nak, ack_seq};
        assertCount++;
        if (got !== RESET_VIEW) begin
            failCount++;
            $display("[TB] FAIL idle_after_reset: got %h, expected %h", got, RESET_VIEW);
        end
    endtask

    task automatic test_good_packet();
        logic [13:0] a;
        logic [33:0] timing;
        logic [31:0] expW[$];
        expW = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
        txWords = expW;
        send_packet(12'd0, 32'h0);
        // One cycle after the eop handshake: ack pulse and first word together.
        timing = {ack_valid, tlp_data_out_valid, tlp_data_out};
        assertCount++;
        if (timing !== {1'b1, 1'b1, 32'hA0000001}) begin
            failCount++;
            $display("[TB] FAIL eop_timing: got %h, expected %h", timing, {1'b1, 1'b1, 32'hA0000001});
        end
        wait_cycles(6);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd0}) begin
            failCount++;
            $display("[TB] FAIL good_ack: got %h, expected %h", a, {1'b1, 1'b0, 12'd0});
        end
        assertCount++;
        if (outQ.size() !== 3) begin
            failCount++;
            $display("[TB] FAIL good_count: got %0d, expected 3", outQ.size());
        end
        for (int i = 0; i < 3 && i < outQ.size(); i++) begin
            assertCount++;
            if (outQ[i] !== expW[i]) begin
                failCount++;
                $display("[TB] FAIL good_word%0d: got %h, expected %h", i, outQ[i], expW[i]);
            end
        end
        outQ.delete();
    endtask

    task automatic test_bad_lcrc();
        logic [13:0] a;
        logic [13:0] exp1;
        logic [13:0] exp2;
        int expN1;
        int expN2;
        logic [31:0] expW[$];
`ifdef RX_DLL_LCRC_CHECK_EN
        exp1 = {1'b1, 1'b1, 12'd0}; expN1 = 0;
        exp2 = {1'b1, 1'b0, 12'd1}; expN2 = 3;
`else
        exp1 = {1'b1, 1'b0, 12'd1}; expN1 = 3;
        exp2 = {1'b1, 1'b1, 12'd1}; expN2 = 0;
`endif
        expW = '{32'hD0000011, 32'hD0000022, 32'hD0000033};
        txWords = expW;
        send_packet(12'd1, 32'h1);
        wait_cycles(6);
        pop_ack(a);
        assertCount++;
        if (a !== exp1) begin
            failCount++;
            $display("[TB] FAIL lcrc_bad_ack: got %h, expected %h", a, exp1);
        end
        assertCount++;
        if (outQ.size() !== expN1) begin
            failCount++;
            $display("[TB] FAIL lcrc_bad_count: got %0d, expected %0d", outQ.size(), expN1);
        end
        outQ.delete();
        send_packet(12'd1, 32'h0);
        wait_cycles(6);
        pop_ack(a);
        assertCount++;
        if (a !== exp2) begin
            failCount++;
            $display("[TB] FAIL lcrc_resend_ack: got %h, expected %h", a, exp2);
        end
        assertCount++;
        if (outQ.size() !== expN2) begin
            failCount++;
            $display("[TB] FAIL lcrc_resend_count: got %0d, expected %0d", outQ.size(), expN2);
        end
        for (int i = 0; i < expN2 && i < outQ.size(); i++) begin
            assertCount++;
            if (outQ[i] !== expW[i]) begin
                failCount++;
                $display("[TB] FAIL lcrc_resend_word%0d: got %h, expected %h", i, outQ[i], expW[i]);
            end
        end
        outQ.delete();
    endtask

    task automatic test_seq_mismatch();
        logic [13:0] a;
        txWords = '{32'h55550001, 32'h55550002};
        send_packet(12'd5, 32'h0);
        wait_cycles(5);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b1, 12'd1}) begin
            failCount++;
            $display("[TB] FAIL seq_mismatch_nak: got %h, expected %h", a, {1'b1, 1'b1, 12'd1});
        end
        assertCount++;
        if (outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL seq_mismatch_count: got %0d, expected 0", outQ.size());
        end
        outQ.delete();
        send_packet(12'd2, 32'h0);
        wait_cycles(5);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd2}) begin
            failCount++;
            $display("[TB] FAIL seq_still_two: got %h, expected %h", a, {1'b1, 1'b0, 12'd2});
        end
        outQ.delete();
    endtask

    task automatic test_backpressure();
        logic [13:0] a;
        logic [32:0] head;
        logic [31:0] expW[$];
        expW = '{32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hF0000001, 32'hF0000002, 32'hF0000003};
        tlp_data_out_ready = 1'b0;
        readyDropped = 1'b0;
        txWords = '{expW[0], expW[1], expW[2]};
        send_packet(12'd3, 32'h0);
        txWords = '{expW[3], expW[4], expW[5]};
        send_packet(12'd4, 32'h0);
        wait_cycles(4);
        assertCount++;
        if (readyDropped !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_ready_high: got dropped=%b, expected 0", readyDropped);
        end
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd3}) begin
            failCount++;
            $display("[TB] FAIL bp_ack3: got %h, expected %h", a, {1'b1, 1'b0, 12'd3});
        end
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd4}) begin
            failCount++;
            $display("[TB] FAIL bp_ack4: got %h, expected %h", a, {1'b1, 1'b0, 12'd4});
        end
        head = {tlp_data_out_valid, tlp_data_out};
        assertCount++;
        if (head !== {1'b1, expW[0]} || outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL bp_held_head: got %h (%0d out), expected %h (0 out)", head, outQ.size(), {1'b1, expW[0]});
        end
        tlp_data_out_ready = 1'b1;
        wait_cycles(10);
        assertCount++;
        if (outQ.size() !== 6) begin
            failCount++;
            $display("[TB] FAIL bp_release_count: got %0d, expected 6", outQ.size());
        end
        for (int i = 0; i < 6 && i < outQ.size(); i++) begin
            assertCount++;
            if (outQ[i] !== expW[i]) begin
                failCount++;
                $display("[TB] FAIL bp_word%0d: got %h, expected %h", i, outQ[i], expW[i]);
            end
        end
        outQ.delete();

        // Oversized packet: 10 TLP words cannot fit an 8-word buffer.
        tlp_data_out_ready = 1'b0;
        readyDropped = 1'b0;
        txWords.delete();
        for (int i = 0; i < 10; i++) txWords.push_back(32'h10000000 + 32'(i));
        send_packet(12'd5, 32'h0);
        wait_cycles(4);
        assertCount++;
        if (readyDropped !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ovf_ready_drop: got dropped=%b, expected 1", readyDropped);
        end
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b1, 12'd4}) begin
            failCount++;
            $display("[TB] FAIL ovf_nak: got %h, expected %h", a, {1'b1, 1'b1, 12'd4});
        end
        tlp_data_out_ready = 1'b1;
        wait_cycles(12);
        assertCount++;
        if (outQ.size() !== 0 || tlp_data_out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ovf_no_output: got %0d words valid=%b, expected 0 words valid=0", outQ.size(), tlp_data_out_valid);
        end
        outQ.delete();
        txWords = '{32'h12345678};
        send_packet(12'd5, 32'h0);
        wait_cycles(5);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd5} || outQ.size() !== 1) begin
            failCount++;
            $display("[TB] FAIL ovf_recover: got %h with %0d words, expected %h with 1 word", a, outQ.size(), {1'b1, 1'b0, 12'd5});
        end
        outQ.delete();
    endtask

    task automatic test_abort();
        logic [13:0] a;
        send_word({20'h5A5A5, 12'd6}, 1'b1, 1'b0);
        send_word(32'h66660001, 1'b0, 1'b0);
        send_word(32'h66660002, 1'b0, 1'b0);
        txWords = '{32'h77770001, 32'h77770002};
        send_packet(12'd6, 32'h0);
        wait_cycles(6);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b1, 12'd5}) begin
            failCount++;
            $display("[TB] FAIL abort_nak: got %h, expected %h", a, {1'b1, 1'b1, 12'd5});
        end
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd6}) begin
            failCount++;
            $display("[TB] FAIL abort_new_ack: got %h, expected %h", a, {1'b1, 1'b0, 12'd6});
        end
        assertCount++;
        if (outQ.size() !== 2 || outQ[0] !== 32'h77770001 || outQ[1] !== 32'h77770002) begin
            failCount++;
            $display("[TB] FAIL abort_words: got %0d words first %h, expected 2 words first 77770001", outQ.size(), (outQ.size() > 0) ? outQ[0] : 32'h0);
        end
        outQ.delete();
    endtask

    task automatic test_runt();
        logic [13:0] a;
        send_word({20'h5A5A5, 12'd7}, 1'b1, 1'b1);
        wait_cycles(3);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b1, 12'd6}) begin
            failCount++;
            $display("[TB] FAIL runt_single: got %h, expected %h", a, {1'b1, 1'b1, 12'd6});
        end
        txWords.delete();
        send_packet(12'd7, 32'h0);
        wait_cycles(3);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b1, 12'd6} || outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL runt_two_word: got %h with %0d words, expected %h with 0", a, outQ.size(), {1'b1, 1'b1, 12'd6});
        end
        outQ.delete();
    endtask

    task automatic test_reset_mid_packet();
        logic [13:0] a;
        logic [47:0] got;
        send_word({20'h5A5A5, 12'd7}, 1'b1, 1'b0);
        send_word(32'h99990001, 1'b0, 1'b0);
        send_word(32'h99990002, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {phy_data_in_ready, tlp_data_out_valid, tlp_data_out, ack_valid, ack_nak, ack_seq};
        assertCount++;
        if (got !== RESET_VIEW) begin
            failCount++;
            $display("[TB] FAIL midreset_values: got %h, expected %h", got, RESET_VIEW);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(2);
        assertCount++;
        if (ackQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL midreset_no_ack: got %0d acks, expected 0", ackQ.size());
        end
        txWords = '{32'hBEEF0001};
        send_packet(12'd0, 32'h0);
        wait_cycles(5);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd0}) begin
            failCount++;
            $display("[TB] FAIL midreset_seq0: got %h, expected %h", a, {1'b1, 1'b0, 12'd0});
        end
        assertCount++;
        if (outQ.size() !== 1 || outQ[0] !== 32'hBEEF0001) begin
            failCount++;
            $display("[TB] FAIL midreset_words: got %0d words, expected only BEEF0001", outQ.size());
        end
        outQ.delete();
    endtask

    task automatic test_wrap();
        logic [13:0] a;
        logic [13:0] lastAck;
        int badAck;
        int badWord;
        badAck = 0;
        badWord = 0;
        lastAck = 14'h0;
        for (int s = 1; s < 4096; s++) begin
            txWords = '{32'hC0000000 | 32'(s)};
            send_packet(12'(s), 32'h0);
        end
        wait_cycles(5);
        for (int s = 1; s < 4096; s++) begin
            pop_ack(a);
            if (a !== {1'b1, 1'b0, 12'(s)}) badAck++;
            lastAck = a;
        end
        for (int i = 0; i < outQ.size(); i++) begin
            if (outQ[i] !== (32'hC0000000 | 32'(i + 1))) badWord++;
        end
        assertCount++;
        if (badAck !== 0) begin
            failCount++;
            $display("[TB] FAIL wrap_acks: got %0d bad acks, expected 0", badAck);
        end
        assertCount++;
        if (outQ.size() !== 4095 || badWord !== 0) begin
            failCount++;
            $display("[TB] FAIL wrap_words: got %0d words %0d bad, expected 4095 words 0 bad", outQ.size(), badWord);
        end
        assertCount++;
        if (lastAck !== {1'b1, 1'b0, 12'hFFF}) begin
            failCount++;
            $display("[TB] FAIL wrap_ack4095: got %h, expected %h", lastAck, {1'b1, 1'b0, 12'hFFF});
        end
        outQ.delete();
        txWords = '{32'hC0000000};
        send_packet(12'd0, 32'h0);
        wait_cycles(5);
        pop_ack(a);
        assertCount++;
        if (a !== {1'b1, 1'b0, 12'd0}) begin
            failCount++;
            $display("[TB] FAIL wrap_ack0: got %h, expected %h", a, {1'b1, 1'b0, 12'd0});
        end
        outQ.delete();
    endtask

    initial begin
        $display("[TB] rx_data_link_layer directed test start");
        test_reset();
        test_good_packet();
        test_bad_lcrc();
        test_seq_mismatch();
        test_backpressure();
        test_abort();
        test_runt();
        test_reset_mid_packet();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
